// File: rtl/riscv_pkg.sv
// Shared pipeline types: the decoded control bundle carried from ID to EX,
// the ALU operation encoding, and the side-effect-free NOP control word.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  // A bubble must never write a register, touch memory or redirect fetch.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_op:     ALU_ADD
  };

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter used for the optional pipeline performance counters.
// Sticks at all-ones instead of wrapping so a long run never reads as short.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, synchronous clear on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register, the consumer end of the load-use stall/flush
// handshake. Priority per edge: rst > stall_ex > (flush_ex | redirect) > load.
// ex_rd / ex_mem_read feed back to the hazard detector, so ex_rd is forced to
// zero whenever the stage does not hold a valid instruction.
// Optional feature: define PIPE_PERF_CNT_EN to build the bubble/hold
// performance counters; otherwise bubble_cnt and hold_cnt are tied to zero.
module id_ex_pipe_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ex,
  input  logic             flush_ex,
  input  logic             redirect,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  ctrl_t            id_ctrl,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output ctrl_t            ex_ctrl,
  output logic             ex_mem_read,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  // flush_ex and redirect collapse into a single bubble request; a stall
  // overrides both, so the held instruction is never lost.
  logic load_bubble;
  assign load_bubble = !stall_ex && (flush_ex || redirect);

  // Stage register: hold on stall, bubble on flush/redirect, else load ID.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every state register in a sequential block is assigned with <=,
    // so all of them sample the pre-edge values and update together.
    if (rst) begin
      // NOTE: every register here is reset, datapath included, so EX comes
      // out of reset as a clean bubble rather than X-valued operands.
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (stall_ex) begin
      // Hold every register.
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      // An invalid ID slot must carry no side effects and no destination,
      // otherwise the hazard detector could see a false dependency.
      ex_rd       <= id_valid ? id_rd : 5'd0;
      ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  assign ex_mem_read = ex_ctrl.mem_read;

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_bubble),
    .clr   (1'b0),
    .count (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_ex),
    .clr   (1'b0),
    .count (hold_cnt)
  );
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

endmodule
